// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;
  localparam logic ARB_M0   = 1'b0;
  localparam logic ARB_M1   = 1'b1;

  typedef enum logic {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY
  } arb_state_e;

  function automatic logic gnt_to_idx(input logic [1:0] gnt);
    return gnt[1] ? ARB_M1 : ARB_M0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both upstream master ports and the downstream memory port.
// The rsp_err strobes exist only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_bus_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            m0_req_valid, m1_req_valid;
  logic            m0_req_ready, m1_req_ready;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [DW-1:0]   m0_data_w, m1_data_w;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb;
  logic            m0_wen, m1_wen;
  logic            m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0]   m0_data_r, m1_data_r;
`ifdef MEM_ARB_TIMEOUT_EN
  logic            m0_rsp_err, m1_rsp_err;
`endif
  logic            mem_mstReq_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_w;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_wen;
  logic [DW-1:0]   mem_data_r;
  logic            mem_slvRsp_valid;

  modport slave (
`ifdef MEM_ARB_TIMEOUT_EN
    output m0_rsp_err, m1_rsp_err,
`endif
    input  m0_req_valid, m1_req_valid, m0_addr, m1_addr, m0_data_w, m1_data_w,
    input  m0_wstrb, m1_wstrb, m0_wen, m1_wen, mem_data_r, mem_slvRsp_valid,
    output m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
    output m0_data_r, m1_data_r, mem_mstReq_valid, mem_addr, mem_data_w,
    output mem_wstrb, mem_wen
  );

  modport master (
`ifdef MEM_ARB_TIMEOUT_EN
    input  m0_rsp_err, m1_rsp_err,
`endif
    output m0_req_valid, m1_req_valid, m0_addr, m1_addr, m0_data_w, m1_data_w,
    output m0_wstrb, m1_wstrb, m0_wen, m1_wen, mem_data_r, mem_slvRsp_valid,
    input  m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
    input  m0_data_r, m1_data_r, mem_mstReq_valid, mem_addr, mem_data_w,
    input  mem_wstrb, mem_wen
  );
endinterface

// File: rtl/gen_dffr.sv
// Library flops: async active-low reset register with and without load enable.
module gen_dffren #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  // Storage with load enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end else begin
      q_o <= q_o;
    end
  end
endmodule

module gen_dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  gen_dffren #(.W(W), .RST_VAL(RST_VAL)) u_ff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (1'b1),
    .d_i   (d_i),
    .q_o   (q_o)
  );
endmodule

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Combinational 2-way round-robin picker producing a one-hot grant.
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);
  // On a tie the master that did not win last time is preferred
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_i == ARB_M1) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master single-outstanding memory bus arbiter with response routing.
// Optional bus timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  mem_bus_arbiter_if.slave     bus
);

  arb_state_e      state_q, state_d;
  logic            state_raw_q;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic            busy_s, rsp_in_s, timeout_s, grant_opp_s, gnt_valid_s, gnt_idx_s;
  logic [1:0]      gnt_s;
  logic [AW-1:0]   addr_s;
  logic [DW-1:0]   data_w_s;
  logic [DW/8-1:0] wstrb_s;
  logic            wen_s;

  gen_dffr #(.W(1), .RST_VAL(ARB_IDLE)) u_state_ff (
    .clk_i(CLK), .rst_ni(RSTn), .d_i(state_d), .q_o(state_raw_q)
  );
  gen_dffr #(.W(1), .RST_VAL(ARB_M0)) u_owner_ff (
    .clk_i(CLK), .rst_ni(RSTn), .d_i(owner_d), .q_o(owner_q)
  );
  // last_grant resets to M1 so that M0 wins the first tie
  gen_dffr #(.W(1), .RST_VAL(ARB_M1)) u_last_ff (
    .clk_i(CLK), .rst_ni(RSTn), .d_i(last_grant_d), .q_o(last_grant_q)
  );

  arb_rr2 u_rr (
    .req_i       ({bus.m1_req_valid, bus.m0_req_valid}),
    .last_grant_i(last_grant_q),
    .gnt_o       (gnt_s)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_en_s;

  // Counter clears on grant and counts BUSY cycles that see no response
  always_comb begin
    cnt_en_s = gnt_valid_s | (busy_s & ~rsp_in_s);
    if (gnt_valid_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  gen_dffren #(.W(CW), .RST_VAL({CW{1'b0}})) u_cnt_ff (
    .clk_i(CLK), .rst_ni(RSTn), .en_i(cnt_en_s), .d_i(cnt_d), .q_o(cnt_q)
  );
`endif

  // Grant opportunity, timeout detection and picker qualification
  always_comb begin
    state_q  = arb_state_e'(state_raw_q);
    busy_s   = (state_q == ST_BUSY);
    rsp_in_s = bus.mem_slvRsp_valid & busy_s;
`ifdef MEM_ARB_TIMEOUT_EN
    timeout_s = busy_s & ~rsp_in_s & (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    timeout_s = 1'b0;
`endif
    grant_opp_s = (~busy_s | rsp_in_s) & ~timeout_s;
    gnt_valid_s = grant_opp_s & (gnt_s != 2'b00);
    gnt_idx_s   = gnt_to_idx(gnt_s);
  end

  // Downstream request mux; fields are zero whenever no request is issued
  always_comb begin
    addr_s   = {AW{1'b0}};
    data_w_s = {DW{1'b0}};
    wstrb_s  = {(DW/8){1'b0}};
    wen_s    = 1'b0;
    if (gnt_valid_s && (gnt_idx_s == ARB_M1)) begin
      addr_s   = bus.m1_addr;
      data_w_s = bus.m1_data_w;
      wstrb_s  = bus.m1_wstrb;
      wen_s    = bus.m1_wen;
    end else if (gnt_valid_s) begin
      addr_s   = bus.m0_addr;
      data_w_s = bus.m0_data_w;
      wstrb_s  = bus.m0_wstrb;
      wen_s    = bus.m0_wen;
    end else begin
      wen_s    = 1'b0;
    end
  end

  // Handshake, downstream and response outputs
  always_comb begin
    bus.m0_req_ready     = grant_opp_s & gnt_s[0];
    bus.m1_req_ready     = grant_opp_s & gnt_s[1];
    bus.mem_mstReq_valid = gnt_valid_s;
    bus.mem_addr         = addr_s;
    bus.mem_data_w       = data_w_s;
    bus.mem_wstrb        = wstrb_s;
    bus.mem_wen          = wen_s;
    bus.m0_rsp_valid     = (rsp_in_s | timeout_s) & (owner_q == ARB_M0);
    bus.m1_rsp_valid     = (rsp_in_s | timeout_s) & (owner_q == ARB_M1);
    bus.m0_data_r        = (rsp_in_s && owner_q == ARB_M0) ? bus.mem_data_r : {DW{1'b0}};
    bus.m1_data_r        = (rsp_in_s && owner_q == ARB_M1) ? bus.mem_data_r : {DW{1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
    bus.m0_rsp_err       = timeout_s & (owner_q == ARB_M0);
    bus.m1_rsp_err       = timeout_s & (owner_q == ARB_M1);
`endif
  end

  // Next-state: a grant always wins; otherwise a completion returns to IDLE
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    if (gnt_valid_s) begin
      state_d      = ST_BUSY;
      owner_d      = gnt_idx_s;
      last_grant_d = gnt_idx_s;
    end else if (rsp_in_s || timeout_s) begin
      state_d      = ST_IDLE;
    end else begin
      state_d      = state_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed table-driven bench for mem_bus_arbiter, plus reset/timeout sequences.
module tb_mem_bus_arbiter;

  localparam logic [63:0] M0_ADDR  = 64'h0000_0000_8000_0010;
  localparam logic [63:0] M0_DATA  = 64'hAAAA_5555_AAAA_5555;
  localparam logic [7:0]  M0_STRB  = 8'hFF;
  localparam logic [63:0] M1_ADDR  = 64'h0000_0000_1000_0040;
  localparam logic [63:0] M1_DATA  = 64'h1122_3344_5566_7788;
  localparam logic [7:0]  M1_STRB  = 8'hF0;
  localparam logic [63:0] IDLE_RD  = 64'hFFFF_0000_FFFF_0000;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_bus_arbiter_if #(.AW(64), .DW(64)) bus ();

  mem_bus_arbiter #(.AW(64), .DW(64), .TIMEOUT_CYC(15)) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        m0_v, m1_v, rsp_v;
    logic [63:0] rdata;
    logic        rdy0, rdy1, mv, sel, rv0, rv1;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic m0_v, logic m1_v, logic rsp_v, logic [63:0] rdata,
                              logic rdy0, logic rdy1, logic mv, logic sel,
                              logic rv0, logic rv1);
    vec_t v;
    v.m0_v = m0_v; v.m1_v = m1_v; v.rsp_v = rsp_v; v.rdata = rdata;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.mv = mv; v.sel = sel; v.rv0 = rv0; v.rv1 = rv1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m0_v, input logic m1_v, input logic rsp_v,
                       input logic [63:0] rdata);
    bus.m0_req_valid     = m0_v;
    bus.m1_req_valid     = m1_v;
    bus.mem_slvRsp_valid = rsp_v;
    bus.mem_data_r       = rsp_v ? rdata : IDLE_RD;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    logic [63:0] e_addr, e_data, e_strb, e_wen;
    e_addr = !v.mv ? 64'd0 : (v.sel ? M1_ADDR : M0_ADDR);
    e_data = !v.mv ? 64'd0 : (v.sel ? M1_DATA : M0_DATA);
    e_strb = !v.mv ? 64'd0 : (v.sel ? {56'd0, M1_STRB} : {56'd0, M0_STRB});
    e_wen  = (v.mv && v.sel) ? 64'd1 : 64'd0;
    check({tag, ".m0_req_ready"}, {63'd0, bus.m0_req_ready}, {63'd0, v.rdy0});
    check({tag, ".m1_req_ready"}, {63'd0, bus.m1_req_ready}, {63'd0, v.rdy1});
    check({tag, ".mem_mstReq_valid"}, {63'd0, bus.mem_mstReq_valid}, {63'd0, v.mv});
    check({tag, ".mem_addr"}, bus.mem_addr, e_addr);
    check({tag, ".mem_data_w"}, bus.mem_data_w, e_data);
    check({tag, ".mem_wstrb"}, {56'd0, bus.mem_wstrb}, e_strb);
    check({tag, ".mem_wen"}, {63'd0, bus.mem_wen}, e_wen);
    check({tag, ".m0_rsp_valid"}, {63'd0, bus.m0_rsp_valid}, {63'd0, v.rv0});
    check({tag, ".m1_rsp_valid"}, {63'd0, bus.m1_rsp_valid}, {63'd0, v.rv1});
    check({tag, ".m0_data_r"}, bus.m0_data_r, v.rv0 ? v.rdata : 64'd0);
    check({tag, ".m1_data_r"}, bus.m1_data_r, v.rv1 ? v.rdata : 64'd0);
  endtask

  initial begin
    //             m0 m1 rsp  rdata                   rdy0 rdy1 mv sel rv0 rv1
    tbl[0]  = mk(0, 0, 0, 64'h0,                    0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 64'h0,                    1, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 64'h11,                   0, 1, 1, 1, 1, 0);
    tbl[3]  = mk(1, 1, 1, 64'h22,                   1, 0, 1, 0, 0, 1);
    tbl[4]  = mk(1, 1, 1, 64'h33,                   0, 1, 1, 1, 1, 0);
    tbl[5]  = mk(0, 0, 1, 64'h44,                   0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 1, 64'h55,                   0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 64'h0,                    1, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 64'h0000_0000_DEAD_BEEF,  0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 1, 0, 64'h0,                    0, 1, 1, 1, 0, 0);
    tbl[10] = mk(0, 0, 1, 64'h66,                   0, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 0, 64'h0,                    1, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 0, 1, 64'h77,                   1, 0, 1, 0, 1, 0);
    tbl[13] = mk(0, 0, 1, 64'h88,                   0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 1, 0, 64'h0,                    0, 1, 1, 1, 0, 0);
    tbl[15] = mk(1, 0, 0, 64'h0,                    0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 64'h0,                    0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 64'h0,                    0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 64'h0,                    0, 0, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 1, 64'h99,                   1, 0, 1, 0, 0, 1);
    tbl[20] = mk(0, 0, 1, 64'hAA,                   0, 0, 0, 0, 1, 0);

    bus.m0_addr = M0_ADDR; bus.m0_data_w = M0_DATA; bus.m0_wstrb = M0_STRB; bus.m0_wen = 1'b0;
    bus.m1_addr = M1_ADDR; bus.m1_data_w = M1_DATA; bus.m1_wstrb = M1_STRB; bus.m1_wen = 1'b1;

    // Reset state, with a stray response that must be dropped
    drive(1'b0, 1'b0, 1'b1, 64'h1234);
    #2;
    check_vec("reset", mk(0, 0, 1, 64'h1234, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      drive(tbl[i].m0_v, tbl[i].m1_v, tbl[i].rsp_v, tbl[i].rdata);
      #2;
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset while BUSY owned by m0 (last grant = m0)
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    #2;
    check_vec("rst_grant", mk(1, 0, 0, 64'h0, 1, 0, 1, 0, 0, 0));
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b1, 64'hBB);
    RSTn = 1'b0;
    #2;
    check_vec("rst_asserted", mk(0, 0, 1, 64'hBB, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    RSTn = 1'b1;
    #2;
    check_vec("rst_late_rsp", mk(0, 0, 1, 64'hBB, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    #2;
    check_vec("rst_tie", mk(1, 1, 0, 64'h0, 1, 0, 1, 0, 0, 0));

`ifdef MEM_ARB_TIMEOUT_EN
    // m0 was just granted; no response ever comes
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLK);
      drive(1'b0, k == 21, k == 20, 64'hCC);
      #2;
      check($sformatf("to%0d.m0_rsp_valid", k), {63'd0, bus.m0_rsp_valid}, {63'd0, k == 15});
      check($sformatf("to%0d.m0_rsp_err", k), {63'd0, bus.m0_rsp_err}, {63'd0, k == 15});
      check($sformatf("to%0d.m1_rsp_err", k), {63'd0, bus.m1_rsp_err}, 64'd0);
      check($sformatf("to%0d.m0_data_r", k), bus.m0_data_r, 64'd0);
      check($sformatf("to%0d.m1_req_ready", k), {63'd0, bus.m1_req_ready}, {63'd0, k == 21});
    end
`endif

    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
